// File: rtl/ps2_spectrum_keyboard.sv
`timescale 1ns/1ps
// ps2_spectrum_keyboard: PS/2 set-2 receiver and decoder driving a ZX Spectrum 8x5 key matrix for the ULA 0xFE read path
module ps2_spectrum_keyboard #(
  parameter int FILTER_LEN   = 8,
  parameter int TIMEOUT_BITS = 14
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  input  logic [15:0] A,
  output logic [4:0]  KEYB,
  output logic        F1,
  output logic        F11
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} st_t;
  logic                    c1, c2, d1, d2, filt, fall, tmo, par, byte_valid, rel, ext;
  logic [FW-1:0]           fcnt;
  logic [TIMEOUT_BITS-1:0] wd;
  logic [2:0]              bcnt;
  logic [7:0]              sr;
  logic [5:0]              src;
  logic [48:0]             held;
  logic [7:0][4:0]         mat;
  logic                    unused_a;
  st_t                     st;
  assign unused_a = ^A[7:0];
  assign fall = filt && !c2 && fcnt == FW'(FILTER_LEN - 1);
  assign tmo  = &wd;
  assign F1   = held[47];
  assign F11  = held[48];
  // two-flop synchronisers for the raw PS/2 pins
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) {c1, c2, d1, d2} <= 4'b1111;
    else {c1, c2, d1, d2} <= {PS2_CLK, c1, PS2_DATA, d1};
  // filtered clock changes only after FILTER_LEN consecutive differing samples
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (c2 == filt) fcnt <= '0;
    else if (fcnt == FW'(FILTER_LEN - 1)) begin
      filt <= c2;
      fcnt <= '0;
    end else fcnt <= fcnt + 1'b1;
  // inter-edge watchdog, cleared by every filtered falling edge
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) wd <= '0;
    else wd <= fall ? '0 : wd + 1'b1;
  // frame receiver: start, 8 data LSB first, odd parity, stop
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      st         <= IDLE;
      bcnt       <= '0;
      sr         <= '0;
      par        <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (fall)
        case (st)
          IDLE: if (!d2) begin
            st   <= DATA;
            bcnt <= '0;
          end
          DATA: begin
            sr   <= {d2, sr[7:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7) st <= PARITY;
          end
          PARITY: begin
            par <= d2;
            st  <= STOP;
          end
          STOP: begin
            byte_valid <= d2 & (^sr ^ par);
            st         <= IDLE;
          end
        endcase
      else if (tmo && st != IDLE) st <= IDLE;
    end
  // scan code to key source: 0..39 matrix keys (row*5+col), 40 right shift, 41 right ctrl,
  // 42 backspace, 43..46 left/down/up/right, 47 F1, 48 F11, 63 unmapped
  always_comb begin
    src = 6'd63;
    case ({ext, sr})
      9'h012: src = 6'd0;
      9'h01A: src = 6'd1;
      9'h022: src = 6'd2;
      9'h021: src = 6'd3;
      9'h02A: src = 6'd4;
      9'h01C: src = 6'd5;
      9'h01B: src = 6'd6;
      9'h023: src = 6'd7;
      9'h02B: src = 6'd8;
      9'h034: src = 6'd9;
      9'h015: src = 6'd10;
      9'h01D: src = 6'd11;
      9'h024: src = 6'd12;
      9'h02D: src = 6'd13;
      9'h02C: src = 6'd14;
      9'h016: src = 6'd15;
      9'h01E: src = 6'd16;
      9'h026: src = 6'd17;
      9'h025: src = 6'd18;
      9'h02E: src = 6'd19;
      9'h045: src = 6'd20;
      9'h046: src = 6'd21;
      9'h03E: src = 6'd22;
      9'h03D: src = 6'd23;
      9'h036: src = 6'd24;
      9'h04D: src = 6'd25;
      9'h044: src = 6'd26;
      9'h043: src = 6'd27;
      9'h03C: src = 6'd28;
      9'h035: src = 6'd29;
      9'h05A: src = 6'd30;
      9'h04B: src = 6'd31;
      9'h042: src = 6'd32;
      9'h03B: src = 6'd33;
      9'h033: src = 6'd34;
      9'h029: src = 6'd35;
      9'h014: src = 6'd36;
      9'h03A: src = 6'd37;
      9'h031: src = 6'd38;
      9'h032: src = 6'd39;
      9'h059: src = 6'd40;
      9'h114: src = 6'd41;
      9'h066: src = 6'd42;
      9'h16B: src = 6'd43;
      9'h172: src = 6'd44;
      9'h175: src = 6'd45;
      9'h174: src = 6'd46;
      9'h005: src = 6'd47;
      9'h078: src = 6'd48;
      default: src = 6'd63;
    endcase
  end
  // prefix tracking and per-source held flags
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      rel  <= 1'b0;
      ext  <= 1'b0;
      held <= '0;
    end else if (byte_valid) begin
      if (sr == 8'hF0) rel <= 1'b1;
      else if (sr == 8'hE0) ext <= 1'b1;
      else begin
        if (src < 6'd49) held[src] <= ~rel;
        rel <= 1'b0;
        ext <= 1'b0;
      end
    end
  // matrix bit is the OR of every source that drives it
  always_comb begin
    mat       = held[39:0];
    mat[0][0] = held[0] | held[40] | (|held[46:42]);
    mat[7][1] = held[36] | held[41];
    mat[4][0] = held[20] | held[42];
    mat[3][4] = held[19] | held[43];
    mat[4][4] = held[24] | held[44];
    mat[4][3] = held[23] | held[45];
    mat[4][2] = held[22] | held[46];
  end
  // active-low column read over all selected half-rows
  always_comb begin
    KEYB = 5'b11111;
    for (int r = 0; r < 8; r++) KEYB = A[8+r] ? KEYB : KEYB & ~mat[r];
  end
endmodule

// File: tb/tb_ps2_spectrum_keyboard.sv
`timescale 1ns/1ps
// tb_ps2_spectrum_keyboard: directed PS/2 frames checked against a held-scan-code model
module tb_ps2_spectrum_keyboard;
  logic        CLK = 0, nRESET = 0, PS2_CLK = 1, PS2_DATA = 1;
  logic [15:0] A = 16'h0000;
  logic [4:0]  KEYB;
  logic        F1, F11;
  int          checks = 0, errors = 0;
  bit          mheld[512];
  bit          mrel, mext, chk_en;

  ps2_spectrum_keyboard dut (.CLK(CLK), .nRESET(nRESET), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
                             .A(A), .KEYB(KEYB), .F1(F1), .F11(F11));

  always #5 CLK = ~CLK;

  function automatic logic [39:0] rc(input int r, input int c);
    logic [39:0] m;
    m = '0;
    m[r*5+c] = 1'b1;
    return m;
  endfunction

  function automatic logic [39:0] keys_of(input logic [8:0] k);
    case (k)
      9'h012, 9'h059: return rc(0, 0);
      9'h01A: return rc(0, 1);
      9'h022: return rc(0, 2);
      9'h021: return rc(0, 3);
      9'h02A: return rc(0, 4);
      9'h01C: return rc(1, 0);
      9'h01B: return rc(1, 1);
      9'h023: return rc(1, 2);
      9'h02B: return rc(1, 3);
      9'h034: return rc(1, 4);
      9'h015: return rc(2, 0);
      9'h01D: return rc(2, 1);
      9'h024: return rc(2, 2);
      9'h02D: return rc(2, 3);
      9'h02C: return rc(2, 4);
      9'h016: return rc(3, 0);
      9'h01E: return rc(3, 1);
      9'h026: return rc(3, 2);
      9'h025: return rc(3, 3);
      9'h02E: return rc(3, 4);
      9'h045: return rc(4, 0);
      9'h046: return rc(4, 1);
      9'h03E: return rc(4, 2);
      9'h03D: return rc(4, 3);
      9'h036: return rc(4, 4);
      9'h04D: return rc(5, 0);
      9'h044: return rc(5, 1);
      9'h043: return rc(5, 2);
      9'h03C: return rc(5, 3);
      9'h035: return rc(5, 4);
      9'h05A: return rc(6, 0);
      9'h04B: return rc(6, 1);
      9'h042: return rc(6, 2);
      9'h03B: return rc(6, 3);
      9'h033: return rc(6, 4);
      9'h029: return rc(7, 0);
      9'h014, 9'h114: return rc(7, 1);
      9'h03A: return rc(7, 2);
      9'h031: return rc(7, 3);
      9'h032: return rc(7, 4);
      9'h066: return rc(0, 0) | rc(4, 0);
      9'h16B: return rc(0, 0) | rc(3, 4);
      9'h172: return rc(0, 0) | rc(4, 4);
      9'h175: return rc(0, 0) | rc(4, 3);
      9'h174: return rc(0, 0) | rc(4, 2);
      default: return '0;
    endcase
  endfunction

  function automatic logic [4:0] exp_keyb(input logic [15:0] a);
    logic [39:0] m;
    logic [4:0]  kb;
    m  = '0;
    kb = 5'b11111;
    for (int k = 0; k < 512; k++) if (mheld[k]) m |= keys_of(9'(k));
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!a[8+r] && m[r*5+c]) kb[c] = 1'b0;
    return kb;
  endfunction

  always @(negedge CLK)
    if (chk_en) begin
      checks++;
      if (KEYB !== exp_keyb(A)) begin
        errors++;
        $display("FAIL model_keyb A=%h got %b want %b", A, KEYB, exp_keyb(A));
      end
      checks++;
      if ({F1, F11} !== {mheld[9'h005], mheld[9'h078]}) begin
        errors++;
        $display("FAIL model_fkeys got F1=%b F11=%b want F1=%b F11=%b", F1, F11, mheld[9'h005], mheld[9'h078]);
      end
    end

  task automatic m_reset();
    for (int k = 0; k < 512; k++) mheld[k] = 0;
    mrel = 0;
    mext = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b == 8'hF0) mrel = 1;
    else if (b == 8'hE0) mext = 1;
    else begin
      mheld[{mext, b}] = !mrel;
      mrel = 0;
      mext = 0;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit good_par, input bit stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ !good_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = f[i];
      repeat (10) @(posedge CLK);
      PS2_CLK = 0;
      repeat (20) @(posedge CLK);
      PS2_CLK = 1;
      repeat (10) @(posedge CLK);
    end
    PS2_DATA = 1;
    repeat (10) @(posedge CLK);
  endtask

  task automatic sweep();
    chk_en = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      #1 A = 16'($urandom);
    end
    @(negedge CLK);
    chk_en = 0;
  endtask

  task automatic key(input logic [7:0] b);
    chk_en = 0;
    send(b, 1, 1, 11);
    m_byte(b);
    sweep();
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(posedge CLK);
    #1 nRESET = 0;
    m_reset();
    PS2_CLK  = 1;
    PS2_DATA = 1;
    chk_en   = 1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    nRESET = 1;
    chk_en = 0;
  endtask

  task automatic lit(input string name, input logic [15:0] a, input logic [4:0] want);
    @(posedge CLK);
    #1 A = a;
    @(negedge CLK);
    checks++;
    if (KEYB !== want) begin
      errors++;
      $display("FAIL %s A=%h got %b want %b", name, a, KEYB, want);
    end
  endtask

  task automatic lit_f(input string name, input bit f11, input bit want);
    @(negedge CLK);
    checks++;
    if ((f11 ? F11 : F1) !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, f11 ? F11 : F1, want);
    end
  endtask

  initial begin
    m_reset();
    chk_en = 1;
    repeat (4) @(posedge CLK);
    lit("rst_keyb", 16'h0000, 5'b11111);
    lit_f("rst_f1", 0, 0);
    lit_f("rst_f11", 1, 0);
    @(negedge CLK);
    nRESET = 1;
    chk_en = 0;
    repeat (5) @(posedge CLK);

    key(8'h1A);
    lit("press_z", 16'hFEFE, 5'b11101);
    key(8'hF0); key(8'h1A);
    lit("rel_z", 16'hFEFE, 5'b11111);

    key(8'h12); key(8'hE0); key(8'h6B);
    lit("left_5", 16'hF7FE, 5'b01111);
    lit("left_caps", 16'hFEFE, 5'b11110);
    key(8'hE0); key(8'hF0); key(8'h6B);
    lit("caps_held", 16'hFEFE, 5'b11110);
    lit("left_5_rel", 16'hF7FE, 5'b11111);
    key(8'hF0); key(8'h12);
    lit("caps_rel", 16'hFEFE, 5'b11111);

    key(8'h05);
    lit_f("f1_press", 0, 1);
    key(8'h05);
    lit_f("f1_repeat", 0, 1);
    key(8'hF0); key(8'h05);
    lit_f("f1_rel", 0, 0);
    key(8'h78);
    lit_f("f11_press", 1, 1);

    send(8'h1C, 0, 1, 11);
    sweep();
    lit("bad_parity", 16'hFDFE, 5'b11111);
    send(8'h1C, 1, 0, 11);
    sweep();
    lit("bad_stop", 16'hFDFE, 5'b11111);
    key(8'h1C);
    lit("a_press", 16'hFDFE, 5'b11110);

    send(8'h29, 1, 1, 5);
    repeat ((1 << 14) + 10) @(posedge CLK);
    key(8'h29);
    lit("watchdog_space", 16'h7FFE, 5'b11110);

    PS2_DATA = 0;
    @(posedge CLK);
    PS2_CLK = 0;
    repeat (3) @(posedge CLK);
    PS2_CLK = 1;
    repeat (20) @(posedge CLK);
    PS2_DATA = 1;
    repeat (10) @(posedge CLK);
    key(8'h2B);
    lit("glitch_f", 16'hFDFE, 5'b10110);

    key(8'hE0); key(8'h14);
    lit("sym_ext", 16'h7FFE, 5'b11100);
    key(8'hF0); key(8'h14);
    lit("sym_still", 16'h7FFE, 5'b11100);
    key(8'hE0); key(8'hF0); key(8'h14);
    lit("sym_rel", 16'h7FFE, 5'b11110);

    key(8'hE0); key(8'h12);
    lit("fake_shift", 16'hFEFE, 5'b11111);

    key(8'h66);
    lit("bksp_rows", 16'hEEFE, 5'b11110);
    lit("bksp_zero", 16'hEFFE, 5'b11110);
    key(8'hF0); key(8'h66);
    lit("bksp_rel", 16'hEEFE, 5'b11111);

    key(8'hE0); key(8'h74);
    lit("right_8", 16'hEFFE, 5'b11011);
    key(8'hE0); key(8'hF0); key(8'h74);

    key(8'h1A); key(8'hF0); key(8'hAA); key(8'h22);
    lit("unmapped_clr", 16'hFEFE, 5'b11001);
    lit("no_rows", 16'hFFFF, 5'b11111);
    lit("all_rows", 16'h00FE, 5'b10000);

    send(8'h22, 1, 1, 6);
    do_reset();
    lit_f("reset_f11", 1, 0);
    lit("reset_keys", 16'h00FE, 5'b11111);
    key(8'hE0); key(8'hF0);
    do_reset();
    key(8'h1A);
    lit("reset_prefix", 16'hFEFE, 5'b11101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_spectrum_keyboard.md
# ps2_spectrum_keyboard

PS/2 keyboard front end that feeds the ULA's port-0xFE read path. Receives PS/2 set-2 scan codes, keeps an 8×5 ZX Spectrum key matrix, and returns the active-low column bits for the half-rows selected by the CPU address high byte. Also exports held-level F1/F11 flags for the host menu logic. Sits between the PS/2 pins and the ULA read mux, in the 14 MHz ULA clock domain.

## Interface
- FILTER_LEN, 8: consecutive identical PS2_CLK samples required before the filtered clock changes.
- TIMEOUT_BITS, 14: width of the inter-edge watchdog; a frame aborts after 2^TIMEOUT_BITS cycles without a filtered falling edge.
- CLK  in  1  ULA clock, 14 MHz; all state on rising edge.
- nRESET  in  1  reset, asynchronous and active-low.
- PS2_CLK  in  1  raw PS/2 clock pin, asynchronous.
- PS2_DATA  in  1  raw PS/2 data pin, asynchronous.
- A  in  16  CPU address bus; A[15:8] selects half-rows, active low.
- KEYB  out  5  column bits, 0 = pressed; combinational from A and the matrix.
- F1  out  1  high while F1 (code 05) is held.
- F11  out  1  high while F11 (code 78) is held.

## Operation
- Input stage: PS2_CLK and PS2_DATA each pass through a 2-flop synchroniser. The filtered clock toggles only after FILTER_LEN equal samples. On each filtered 1→0 edge, the synchronised data bit is sampled.
- Receiver FSM:
  - IDLE: start bit 0 → DATA; start bit 1 → stay in IDLE.
  - DATA: 8 bits, LSB first → PARITY.
  - PARITY → STOP.
  - STOP: stop = 1 and odd parity correct → one-cycle byte_valid; in all cases return to IDLE.
  - A bad parity or bad stop bit discards the byte silently.
  - Watchdog: counter clears on every filtered falling edge. On overflow in any state other than IDLE, return to IDLE.
- Decoder, acting on byte_valid:
  - F0 sets the release flag; E0 sets the extended flag. Repeated prefixes keep their flag set.
  - Any other byte is looked up with the current extended flag, applied (release flag clear → press, set → release), then both flags clear.
  - Unmapped codes, including AA/FA/EE/FE/E1, change no key and still clear both flags.
  - Pressing an already-pressed key, or releasing an already-released key, is a no-op. Typematic repeats are therefore harmless.
- Matrix (row = A bit, columns bit0..bit4):
  - A8: CAPS, Z, X, C, V.
  - A9: A, S, D, F, G.
  - A10: Q, W, E, R, T.
  - A11: 1, 2, 3, 4, 5.
  - A12: 0, 9, 8, 7, 6.
  - A13: P, O, I, U, Y.
  - A14: ENTER, L, K, J, H.
  - A15: SPACE, SYM, M, N, B.
- Set-2 codes by row:
  - A8: 12/59, 1A, 22, 21, 2A.
  - A9: 1C, 1B, 23, 2B, 34.
  - A10: 15, 1D, 24, 2D, 2C.
  - A11: 16, 1E, 26, 25, 2E.
  - A12: 45, 46, 3E, 3D, 36.
  - A13: 4D, 44, 43, 3C, 35.
  - A14: 5A, 4B, 42, 3B, 33.
  - A15: 29, 14/E0 14, 3A, 31, 32.
- Compound keys set CAPS plus one digit:
  - 66 (backspace) → CAPS+0.
  - E0 6B (left) → CAPS+5.
  - E0 72 (down) → CAPS+6.
  - E0 75 (up) → CAPS+7.
  - E0 74 (right) → CAPS+8.
- Every source key has its own held flag; a matrix bit is the OR of its sources. Releasing an arrow therefore never clears CAPS while a real shift is still held.
- Unprefixed 12, 59 and 14 map as listed. The E0-prefixed forms E0 12 and E0 59 (fake shifts) are ignored.
- Read path: KEYB[c] = NOT( OR over r where A[8+r]=0 of key[r][c] ). When A[15:8] = FF, KEYB = 11111.

## Timing
- Reset (asynchronous assert; deassert synchronous to CLK):
  - KEYB = 11111 for any A.
  - F1 = F11 = 0.
  - FSM in IDLE, both prefix flags clear, watchdog cleared, all key flags released.
- Reset mid-frame drops the partial byte. Reset mid-prefix clears the flags.
- Latency from the raw stop-bit falling edge to the matrix/F-flag update is at most 2 (sync) + FILTER_LEN + 2 cycles, i.e. ≤12 cycles at the defaults.
- KEYB responds to A combinationally, with zero cycles from a matrix update to output.
- A byte_valid arriving in the same cycle as the watchdog expiring: the byte is processed and the FSM goes to IDLE.
- Glitches on PS2_CLK shorter than FILTER_LEN cycles produce no edge.

## Test plan
- Reset with A=0000 → KEYB=11111, F1=0, F11=0.
- Send 1A, then A=FEFE → KEYB=11101. Send F0 1A → KEYB=11111.
- Send 12, then E0 6B; A=F7FE → KEYB=01111 (row A11 bit4 pressed); A=FEFE → 11110. Send E0 F0 6B; A=FEFE → still 11110 (left shift held). Send F0 12 → 11111.
- Send 05 → F1=1. Send 05 again (typematic) → F1 stays 1. Send F0 05 → F1=0. Send 78 → F11=1.
- Frame 1C with wrong parity → no change. Frame with stop=0 → no change. Then 1C with valid parity; A=FDFE → KEYB=11110.
- Send half a frame, idle 2^14+10 cycles, then a full 29 frame; A=7FFE → KEYB=11110. Also: 3-cycle PS2_CLK glitch → no bit shifted in.
